// File: rtl/alu_pkg.sv
// Shared ALU encodings: opcodes, mux select codes, sequencer states and the decode function.
// The mux reuses the select constants so both sides agree on the encoding.
package alu_pkg;

  localparam int unsigned CntW = 4;

  localparam logic [2:0] OP_ADD     = 3'd0;
  localparam logic [2:0] OP_SUB     = 3'd1;
  localparam logic [2:0] OP_AND     = 3'd2;
  localparam logic [2:0] OP_OR      = 3'd3;
  localparam logic [2:0] OP_XOR     = 3'd4;
  localparam logic [2:0] OP_SHL     = 3'd5;
  localparam logic [2:0] OP_MUL     = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  // 3'b010 is deliberately unused on the mux select.
  localparam logic [2:0] SEL_IN1 = 3'b000;
  localparam logic [2:0] SEL_IN2 = 3'b001;
  localparam logic [2:0] SEL_IN3 = 3'b011;
  localparam logic [2:0] SEL_IN4 = 3'b100;
  localparam logic [2:0] SEL_IN5 = 3'b110;
  localparam logic [2:0] SEL_IN6 = 3'b101;
  localparam logic [2:0] SEL_IN7 = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } seq_state_e;

  function automatic logic [2:0] op_to_sel(input logic [2:0] op);
    logic [2:0] sel;
    unique case (op)
      OP_ADD:  sel = SEL_IN1;
      OP_SUB:  sel = SEL_IN2;
      OP_AND:  sel = SEL_IN3;
      OP_OR:   sel = SEL_IN4;
      OP_XOR:  sel = SEL_IN5;
      OP_SHL:  sel = SEL_IN6;
      OP_MUL:  sel = SEL_IN7;
      default: sel = SEL_IN1;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Request/response sequencer in front of the 7:1 ALU result mux: decodes the opcode to a
// held select, waits out the unit latency, then registers and presents the mux output.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned size    = 8,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  output logic [2:0]      sel,
  output logic            mul_start,
  input  logic [size-1:0] mux_out,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [size-1:0] rsp_data,
  output logic            rsp_err
);

  localparam logic [CntW-1:0] MulLoad = CntW'(MUL_LAT - 1);

  seq_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      sel_q, sel_d;
  logic            mul_start_q, mul_start_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [size-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    mul_start_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_op == OP_ILLEGAL) begin
            // Illegal ops skip execution; sel keeps the last legal decode.
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = StResp;
          end else begin
            sel_d       = op_to_sel(req_op);
            cnt_d       = (req_op == OP_MUL) ? MulLoad : '0;
            mul_start_d = (req_op == OP_MUL);
            state_d     = StExec;
          end
        end
      end
      StExec: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - {{(CntW-1){1'b0}}, 1'b1};
        end else begin
          rsp_data_d  = mux_out;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sel_q       <= SEL_IN1;
      mul_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      mul_start_q <= mul_start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign sel       = sel_q;
  assign mul_start = mul_start_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with hand-computed expectations (size 8, MUL_LAT 4).
module tb_alu_op_sequencer;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [2:0] sel;
  logic       mul_start;
  logic [7:0] mux_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;

  int total;
  int bad;

  alu_op_sequencer #(
    .size   (8),
    .MUL_LAT(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .sel      (sel),
    .mul_start(mul_start),
    .mux_out  (mux_out),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 3'd0;
    mux_out   = 8'h00;
    rsp_ready = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_mul_start", 32'(mul_start), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_req_ready", 32'(req_ready), 32'h1);

    // Op 2 -> sel 011, one-cycle latency
    req_valid = 1'b1;
    req_op    = 3'd2;
    mux_out   = 8'h3C;
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("op2_sel", 32'(sel), 32'h3);
    chk("op2_req_ready_busy", 32'(req_ready), 32'h0);
    chk("op2_rsp_valid_early", 32'(rsp_valid), 32'h0);
    chk("op2_no_mul_start", 32'(mul_start), 32'h0);
    tick();
    chk("op2_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("op2_rsp_data", 32'(rsp_data), 32'h3C);
    chk("op2_rsp_err", 32'(rsp_err), 32'h0);
    tick();
    chk("op2_done_valid", 32'(rsp_valid), 32'h0);
    chk("op2_idle", 32'(req_ready), 32'h1);

    // Op 6 -> sel 111, mul_start one cycle, response after 4 cycles
    req_valid = 1'b1;
    req_op    = 3'd6;
    mux_out   = 8'hA5;
    tick();
    req_valid = 1'b0;
    chk("mul_sel", 32'(sel), 32'h7);
    chk("mul_start_pulse", 32'(mul_start), 32'h1);
    tick();
    chk("mul_start_clear", 32'(mul_start), 32'h0);
    chk("mul_valid_c1", 32'(rsp_valid), 32'h0);
    tick();
    chk("mul_valid_c2", 32'(rsp_valid), 32'h0);
    tick();
    chk("mul_valid_c3", 32'(rsp_valid), 32'h0);
    chk("mul_start_c3", 32'(mul_start), 32'h0);
    tick();
    chk("mul_valid_c4", 32'(rsp_valid), 32'h1);
    chk("mul_rsp_data", 32'(rsp_data), 32'hA5);
    tick();
    chk("mul_done", 32'(rsp_valid), 32'h0);

    // Op 4 then illegal op 7
    req_valid = 1'b1;
    req_op    = 3'd4;
    mux_out   = 8'h5A;
    tick();
    req_valid = 1'b0;
    chk("op4_sel", 32'(sel), 32'h6);
    tick();
    chk("op4_rsp_data", 32'(rsp_data), 32'h5A);
    tick();
    req_valid = 1'b1;
    req_op    = 3'd7;
    rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    chk("ill_sel_held", 32'(sel), 32'h6);
    chk("ill_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("ill_rsp_err", 32'(rsp_err), 32'h1);
    chk("ill_rsp_data", 32'(rsp_data), 32'h0);
    chk("ill_no_mul_start", 32'(mul_start), 32'h0);
    rsp_ready = 1'b1;
    tick();
    chk("ill_done", 32'(rsp_valid), 32'h0);
    chk("ill_idle", 32'(req_ready), 32'h1);

    // Backpressure with a second request held pending
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_op    = 3'd0;
    mux_out   = 8'h11;
    tick();
    chk("bp_sel", 32'(sel), 32'h0);
    tick();
    chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("bp_rsp_data", 32'(rsp_data), 32'h11);
    chk("bp_rsp_err_clear", 32'(rsp_err), 32'h0);
    mux_out = 8'h22;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_data", 32'(rsp_data), 32'h11);
      chk("bp_hold_valid", 32'(rsp_valid), 32'h1);
      chk("bp_req_ready_low", 32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_consumed", 32'(rsp_valid), 32'h0);
    chk("bp_idle_gap", 32'(req_ready), 32'h1);
    tick();
    req_valid = 1'b0;
    chk("bp_second_accept", 32'(req_ready), 32'h0);
    tick();
    chk("bp_second_valid", 32'(rsp_valid), 32'h1);
    chk("bp_second_data", 32'(rsp_data), 32'h22);
    tick();
    chk("bp_second_done", 32'(rsp_valid), 32'h0);

    // Reset in the middle of a multiply
    req_valid = 1'b1;
    req_op    = 3'd6;
    mux_out   = 8'h99;
    tick();
    req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_exec_valid", 32'(rsp_valid), 32'h0);
    chk("rst_exec_mul_start", 32'(mul_start), 32'h0);
    chk("rst_exec_idle", 32'(req_ready), 32'h1);
    chk("rst_exec_sel", 32'(sel), 32'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rst_exec_no_rsp", 32'(rsp_valid), 32'h0);
    end

    // Recovery with op 1
    req_valid = 1'b1;
    req_op    = 3'd1;
    mux_out   = 8'h77;
    tick();
    req_valid = 1'b0;
    chk("rec_sel", 32'(sel), 32'h1);
    tick();
    chk("rec_rsp_data", 32'(rsp_data), 32'h77);
    chk("rec_rsp_valid", 32'(rsp_valid), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
